// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: word width, RV32I
// load/store size codes and the responder state encoding.
package mem_pkg;

  localparam int WORD_W = 32;

  // funct3 size/sign codes shared by loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for one access: store byte enables and replicated write
// word, sign/zero-extended load word, and alignment/encoding error flags.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic              is_store,
  input  logic [1:0]        addr_lo,
  input  logic [WORD_W-1:0] wdata,
  input  logic [WORD_W-1:0] rword,
  output logic [3:0]        be,
  output logic [WORD_W-1:0] wword,
  output logic [WORD_W-1:0] rdata_ext,
  output logic              misalign,
  output logic              bad_funct3
);

  logic [WORD_W-1:0] shifted;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  // Decode size code into lanes, extension and error flags
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    be         = '0;
    wword      = '0;
    rdata_ext  = '0;
    misalign   = 1'b0;
    bad_funct3 = 1'b0;
    shifted    = rword >> {addr_lo, 3'b000};
    byte_sel   = shifted[7:0];
    half_sel   = addr_lo[1] ? rword[31:16] : rword[15:0];

    case (funct3)
      F3_B: begin
        be        = 4'b0001 << addr_lo;
        wword     = {4{wdata[7:0]}};
        rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H: begin
        misalign  = addr_lo[0];
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword     = {2{wdata[15:0]}};
        rdata_ext = {{16{half_sel[15]}}, half_sel};
      end
      F3_W: begin
        misalign  = (addr_lo != 2'b00);
        be        = 4'b1111;
        wword     = wdata;
        rdata_ext = rword;
      end
      F3_BU: begin
        bad_funct3 = is_store;
        rdata_ext  = {24'd0, byte_sel};
      end
      F3_HU: begin
        misalign   = addr_lo[0];
        bad_funct3 = is_store;
        rdata_ext  = {16'd0, half_sel};
      end
      default: bad_funct3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY
// cycles, then performs the RAM access and presents a one-cycle response.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              hs;
  logic              enter_resp;
  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic [2:0]        acc_funct3;
  logic              range_err, acc_err, ram_we;
  logic [IDX_W-1:0]  ram_idx;
  logic [WORD_W-1:0] rword, wword, rdata_ext;
  logic [3:0]        be;
  logic              misalign, bad_funct3;

  logic [WORD_W-1:0] ram [DEPTH];

  assign hs = req_valid & req_ready;

  // State, counter, request latch and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next state: accept in IDLE, count down in BUSY, single response cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    unique case (state_q)
      IDLE: if (hs) begin
        we_d     = req_we;
        addr_d   = req_addr;
        wdata_d  = req_wdata;
        funct3_d = req_funct3;
        cnt_d    = CNT_INIT;
        state_d  = (LATENCY > 1) ? BUSY : RESP;
      end
      BUSY: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and response strobe follow the current state only
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = rsp_rdata_q;
    rsp_err   = rsp_err_q;
  end

  // With LATENCY=1 the RAM access happens on the accept edge itself, so the
  // access fields come straight from the request port while still in IDLE.
  always_comb begin
    acc_we      = (state_q == IDLE) ? req_we     : we_q;
    acc_addr    = (state_q == IDLE) ? req_addr   : addr_q;
    acc_wdata   = (state_q == IDLE) ? req_wdata  : wdata_q;
    acc_funct3  = (state_q == IDLE) ? req_funct3 : funct3_q;
    enter_resp  = (state_d == RESP) && (state_q != RESP);
    range_err   = (acc_addr[31:2] >= 30'(DEPTH));
    acc_err     = range_err | misalign | bad_funct3;
    ram_we      = enter_resp & acc_we & ~acc_err;
    ram_idx     = acc_addr[IDX_W+1:2];
    rword       = ram[ram_idx];
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (enter_resp) begin
      rsp_err_d   = acc_err;
      rsp_rdata_d = (acc_err || acc_we) ? '0 : rdata_ext;
    end
  end

  mem_lane_align u_align (
    .funct3     (acc_funct3),
    .is_store   (acc_we),
    .addr_lo    (acc_addr[1:0]),
    .wdata      (acc_wdata),
    .rword      (rword),
    .be         (be),
    .wword      (wword),
    .rdata_ext  (rdata_ext),
    .misalign   (misalign),
    .bad_funct3 (bad_funct3)
  );

  // Byte-enabled RAM write; a reset on the same edge suppresses the store
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset; its contents are undefined until
    // written, and only the write enable is gated by rst.
    if (ram_we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram[ram_idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: lane handling, errors, latency,
// reset abandonment and back-to-back acceptance at LATENCY 1 and 3.
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // main instance, LATENCY=2
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  // back-to-back instances share the payload, each has its own valid
  logic        b_we = 1'b1;
  logic [31:0] b_addr = 32'h8, b_wdata = 32'h12345678;
  logic [2:0]  b_funct3 = 3'b010;
  logic        v1 = 1'b0, v3 = 1'b0;
  logic        r1, r3, rv1, rv3, re1, re3;
  logic [31:0] rd1, rd3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err));

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(r1),
    .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata),
    .req_funct3(b_funct3), .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1));

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(r3),
    .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata),
    .req_funct3(b_funct3), .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(re3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on the main instance with full handshake/latency checking
  task automatic transact(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3,
                          input logic [31:0] exp_rdata, input logic exp_err);
    int cyc;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, ".busy_ready"}, 32'(req_ready), 32'd0);
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, 32'(cyc), 32'(LAT));
    check({tag, ".rdata"}, rsp_rdata, exp_rdata);
    check({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
    @(negedge clk);
    check({tag, ".pulse"}, 32'(rsp_valid), 32'd0);
    check({tag, ".hold"}, rsp_rdata, exp_rdata);
  endtask

  initial begin
    int pulses, n1, n3, low1, low3;
    int idx1 [4];
    int idx3 [4];

    // reset state
    #12;
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.valid", 32'(rsp_valid), 32'd0);
    check("rst.rdata", rsp_rdata, 32'd0);
    check("rst.err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // word store/load
    transact("sw10", 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
    transact("lw10", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);
    // byte lanes
    transact("sb13", 1'b1, 32'h13, 32'h00000080, 3'b000, 32'h0, 1'b0);
    transact("lb13", 1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0);
    transact("lbu13", 1'b0, 32'h13, 32'h0, 3'b100, 32'h00000080, 1'b0);
    transact("lw10b", 1'b0, 32'h10, 32'h0, 3'b010, 32'h80ADBEEF, 1'b0);
    // half lanes
    transact("sh12", 1'b1, 32'h12, 32'h00001234, 3'b001, 32'h0, 1'b0);
    transact("lh12", 1'b0, 32'h12, 32'h0, 3'b001, 32'h00001234, 1'b0);
    transact("lhu10", 1'b0, 32'h10, 32'h0, 3'b101, 32'h0000BEEF, 1'b0);
    transact("lh10", 1'b0, 32'h10, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0);
    transact("lb10", 1'b0, 32'h10, 32'h0, 3'b000, 32'hFFFFFFEF, 1'b0);
    // last word in range, and word 0 as a wrap-around witness
    transact("swfc", 1'b1, 32'hFC, 32'h55AA55AA, 3'b010, 32'h0, 1'b0);
    transact("lwfc", 1'b0, 32'hFC, 32'h0, 3'b010, 32'h55AA55AA, 1'b0);
    transact("sw0", 1'b1, 32'h0, 32'h0BADF00D, 3'b010, 32'h0, 1'b0);
    // error cases
    transact("lw11", 1'b0, 32'h11, 32'h0, 3'b010, 32'h0, 1'b1);
    transact("lh13", 1'b0, 32'h13, 32'h0, 3'b001, 32'h0, 1'b1);
    transact("sw_oor", 1'b1, 32'h100, 32'hFFFFFFFF, 3'b010, 32'h0, 1'b1);
    transact("ld_f3_011", 1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1);
    transact("sh11", 1'b1, 32'h11, 32'h0000FFFF, 3'b001, 32'h0, 1'b1);
    transact("st_f3_100", 1'b1, 32'h10, 32'h000000FF, 3'b100, 32'h0, 1'b1);
    transact("lw10c", 1'b0, 32'h10, 32'h0, 3'b010, 32'h1234BEEF, 1'b0);
    transact("lw0", 1'b0, 32'h0, 32'h0, 3'b010, 32'h0BADF00D, 1'b0);

    // reset while BUSY abandons a store
    transact("sw20", 1'b1, 32'h20, 32'h11112222, 3'b010, 32'h0, 1'b0);
    transact("lw20pre", 1'b0, 32'h20, 32'h0, 3'b010, 32'h11112222, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_funct3 = 3'b010;
    check("abort.ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) rst = 1'b0;
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check("abort.no_rsp", 32'(pulses), 32'd0);
    check("abort.ready_after", 32'(req_ready), 32'd1);
    check("abort.rdata_cleared", rsp_rdata, 32'd0);
    transact("lw20post", 1'b0, 32'h20, 32'h0, 3'b010, 32'h11112222, 1'b0);

    // back-to-back with valid held, LATENCY 1 and 3
    @(negedge clk);
    v1 = 1'b1; v3 = 1'b1;
    n1 = 0; n3 = 0; low1 = 0; low3 = 0;
    for (int c = 0; c < 24; c++) begin
      if (v1) begin
        if (r1) begin idx1[n1] = c; n1++; end
        else low1++;
      end
      if (v3) begin
        if (r3) begin idx3[n3] = c; n3++; end
        else low3++;
      end
      @(negedge clk);
      if (n1 == 4) v1 = 1'b0;
      if (n3 == 4) v3 = 1'b0;
    end
    v1 = 1'b0; v3 = 1'b0;
    check("b2b1.count", 32'(n1), 32'd4);
    check("b2b3.count", 32'(n3), 32'd4);
    if (n1 == 4) begin
      for (int k = 1; k < 4; k++) check("b2b1.spacing", 32'(idx1[k] - idx1[0]), 32'(k * 2));
    end
    if (n3 == 4) begin
      for (int k = 1; k < 4; k++) check("b2b3.spacing", 32'(idx3[k] - idx3[0]), 32'(k * 4));
    end
    check("b2b1.ready_low", 32'(low1), 32'd3);
    check("b2b3.ready_low", 32'(low3), 32'd9);
    repeat (4) @(negedge clk);
    check("b2b1.idle_ready", 32'(r1), 32'd1);
    check("b2b3.idle_ready", 32'(r3), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
